phase1_addr_gen: RTL and testbench
==================================

# phase1_addr_gen

Address-generation and result-capture stage that drives one `bram_phase1` lookup table in the RFC classifier pipeline. It accepts a pair of phase-0 equivalence-class IDs plus a packet tag and forms the cross-product index `id_a * cfg_num_b + id_b`. It then issues the synchronous BRAM read and buffers the returned phase-1 class ID in a small output FIFO with valid/ready flow control. Upstream is the phase-0 result merge; downstream is the next phase (phase-2 address generation).

## Interface
- `ADDR_WIDTH`, 32: BRAM address width; must match the attached `bram_phase1`.
- `DATA_WIDTH`, 32: BRAM data width, which is also the result width.
- `DEPTH`, 32768: number of valid BRAM entries, used for the bounds check.
- `ID_A_WIDTH`, 16: width of the first phase-0 class ID.
- `ID_B_WIDTH`, 16: width of the second phase-0 class ID and of `cfg_num_b`.
- `TAG_WIDTH`, 8: opaque packet tag carried alongside each lookup.
- `FIFO_DEPTH`, 4: output buffer entries; power of 2, minimum 4.
- `clka` in 1: the block's single clock; shared with the BRAM.
- `rsta` in 1: reset; synchronous and active-high.
- `cfg_num_b` in ID_B_WIDTH: number of classes in phase-0 table B, i.e. the row stride; static while traffic flows.
- `s_valid` in 1: request valid.
- `s_ready` out 1: request ready.
- `s_id_a` in ID_A_WIDTH: phase-0 class A.
- `s_id_b` in ID_B_WIDTH: phase-0 class B.
- `s_tag` in TAG_WIDTH: packet tag.
- `bram_ena` out 1: BRAM read enable, connected to `ena`.
- `bram_addra` out ADDR_WIDTH: BRAM address, connected to `addra`.
- `bram_douta` in DATA_WIDTH: BRAM read data, connected to `douta`.
- `m_valid` out 1: result valid.
- `m_ready` in 1: result ready.
- `m_eqid` out DATA_WIDTH: phase-1 class ID.
- `m_tag` out TAG_WIDTH: tag of this result.
- `m_oob` out 1: the lookup index was out of range.

## Operation
- **Accept.** A request is accepted on any edge where `s_valid && s_ready`.
- **Index arithmetic.** The index is `id_a * cfg_num_b + id_b`.
  - The product is computed at full width ID_A_WIDTH+ID_B_WIDTH; the sum is one bit wider.
  - The index is zero-extended or truncated to ADDR_WIDTH for `bram_addra`.
- **Stage 1 (registered outputs).** Holds `bram_ena`, `bram_addra`, the tag, the oob bit and a valid bit. `bram_ena` equals the stage-1 valid bit.
- **Stage 2.** A valid bit, tag and oob bit aligned with `bram_douta`, which arrives one cycle after `bram_ena`.
- **FIFO write.** When stage-2 valid is set, the entry {douta, tag, oob} is written into the FIFO.
  - If oob is set, 0 is written in place of douta.
- **Credit counter.** Width clog2(FIFO_DEPTH)+1.
  - Counts stage-1 + stage-2 + FIFO entries.
  - Increments on accept and decrements on pop (`m_valid && m_ready`); both in the same cycle leaves it unchanged.
  - `s_ready = (credits < FIFO_DEPTH)`, decoded from the registered count only. There is no combinational path from `m_ready` to `s_ready`.
- **Ordering.** Results leave in acceptance order. The FIFO can never overflow because of the credit counter.
- **FIFO outputs.** `m_valid` = FIFO not empty. `m_eqid`, `m_tag` and `m_oob` show the head entry and are stable while `m_valid && !m_ready`.
- **Reset behaviour.** `rsta` clears all valid bits, FIFO pointers and the credit counter.
  - In-flight reads are discarded, and BRAM data returning after reset is ignored.
  - Reset values: `s_ready` 0 while `rsta` is high, 1 on the first cycle after. `bram_ena` 0, `bram_addra` 0, `m_valid` 0, `m_eqid` 0, `m_tag` 0, `m_oob` 0.

## Timing
- Request accepted on edge T → `bram_ena`=1 with `bram_addra` valid during cycle T+1.
- `bram_douta` valid during cycle T+2 and written to the FIFO on edge T+2 end.
- `m_valid` high in cycle T+3 when the FIFO was empty. Latency is 3 cycles.
- Throughput is 1 lookup/cycle sustained when `m_ready` is held high (FIFO_DEPTH ≥ 4 covers the credit round trip).
- A pop on edge E frees its credit, so `s_ready` may rise in cycle E+1.
- `m_ready` low: exactly FIFO_DEPTH requests are accepted, then `s_ready`=0 until the first pop.

## Configuration
- **`PHASE1_BOUNDS_CHECK_EN` defined:**
  - oob = (`id_b >= cfg_num_b`) or (full-width index ≥ DEPTH).
  - On oob, `bram_addra` is forced to 0, `bram_ena` is still pulsed, `m_eqid`=0 and `m_oob`=1.
- **`PHASE1_BOUNDS_CHECK_EN` undefined:**
  - No comparators are built and `m_oob` is tied 0.
  - The address is the truncated index and `m_eqid` is the raw BRAM data.

## Test plan
- **Single lookup.** `cfg_num_b`=10, id_a=3, id_b=7, tag=0x5A accepted at T → `bram_addra`=37 with `bram_ena`=1 at T+1. At T+3, `m_valid`=1, `m_eqid`=mem[37], `m_tag`=0x5A, `m_oob`=0.
- **Streaming.** 16 back-to-back requests with `m_ready`=1 → `s_ready` never drops. 16 results arrive on consecutive cycles in order, starting T+3.
- **Backpressure.** `m_ready`=0 with continuous `s_valid` → exactly 4 accepts, then `s_ready`=0. `m_eqid` is held stable. After `m_ready`=1 all 4 drain in order with no loss or duplication.
- **Out of range.** With `PHASE1_BOUNDS_CHECK_EN` defined:
  - id_b=10, `cfg_num_b`=10 → `m_oob`=1, `m_eqid`=0, `bram_addra`=0.
  - id_a=3276, `cfg_num_b`=10, id_b=8 (index 32768) → `m_oob`=1.
- **Reset mid-flight.** Two requests in flight and one in the FIFO, `rsta` high for 1 cycle → `m_valid`=0 and credits=0 next cycle. No stale result appears afterwards, and `s_ready`=1 on the cycle after `rsta` drops.
- **Simultaneous accept and pop at full credit.** Accept and pop on the same edge → credits unchanged, output order preserved.

Source files
------------

// File: rtl/phase1_addr_gen.sv
// Phase-1 RFC lookup: index = id_a*cfg_num_b+id_b -> bram_phase1 read -> result FIFO; 3-cycle latency.
// s_ready comes from a registered credit count (no m_ready path); `PHASE1_BOUNDS_CHECK_EN adds the oob check.
module phase1_addr_gen #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32768,
  parameter int ID_A_WIDTH = 16,
  parameter int ID_B_WIDTH = 16,
  parameter int TAG_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic [ID_B_WIDTH-1:0] cfg_num_b,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [ID_A_WIDTH-1:0] s_id_a,
  input  logic [ID_B_WIDTH-1:0] s_id_b,
  input  logic [TAG_WIDTH-1:0]  s_tag,
  output logic                  bram_ena,
  output logic [ADDR_WIDTH-1:0] bram_addra,
  input  logic [DATA_WIDTH-1:0] bram_douta,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_eqid,
  output logic [TAG_WIDTH-1:0]  m_tag,
  output logic                  m_oob
);

  localparam int PROD_W = ID_A_WIDTH + ID_B_WIDTH;
  localparam int IDX_W  = PROD_W + 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CRED_W = PTR_W + 1;
  localparam int ENT_W  = DATA_WIDTH + TAG_WIDTH + 1;

  logic                  accept;
  logic                  pop;
  logic [PROD_W-1:0]     prod;
  logic [IDX_W-1:0]      idx;
  logic                  req_oob;
  logic [ADDR_WIDTH-1:0] req_addr;

  logic                  s1_vld_q, s1_vld_d;
  logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
  logic [TAG_WIDTH-1:0]  s1_tag_q, s1_tag_d;
  logic                  s1_oob_q, s1_oob_d;
  logic                  s2_vld_q, s2_vld_d;
  logic [TAG_WIDTH-1:0]  s2_tag_q, s2_tag_d;
  logic                  s2_oob_q, s2_oob_d;

  logic [CRED_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CRED_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CRED_W-1:0]     cred_q, cred_d;
  logic [ENT_W-1:0]      fifo_q [FIFO_DEPTH];
  logic [ENT_W-1:0]      fifo_d [FIFO_DEPTH];
  logic [ENT_W-1:0]      head;

  assign s_ready = !rsta && (cred_q < CRED_W'(FIFO_DEPTH));
  assign accept  = s_valid && s_ready;
  assign m_valid = (wr_ptr_q != rd_ptr_q);
  assign pop     = m_valid && m_ready;

  // Full-width product plus one carry bit so the range check sees the true index.
  always_comb begin
    prod = PROD_W'(s_id_a) * PROD_W'(cfg_num_b);
    idx  = {1'b0, prod} + IDX_W'(s_id_b);
`ifdef PHASE1_BOUNDS_CHECK_EN
    req_oob = (s_id_b >= cfg_num_b) || (idx >= IDX_W'(DEPTH));
`else
    req_oob = 1'b0;
`endif
    req_addr = req_oob ? '0 : ADDR_WIDTH'(idx);
  end

  always_comb begin
    s1_vld_d  = accept;
    s1_addr_d = s1_addr_q;
    s1_tag_d  = s1_tag_q;
    s1_oob_d  = s1_oob_q;
    if (accept) begin
      s1_addr_d = req_addr;
      s1_tag_d  = s_tag;
      s1_oob_d  = req_oob;
    end
    s2_vld_d = s1_vld_q;
    s2_tag_d = s1_tag_q;
    s2_oob_d = s1_oob_q;
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q + CRED_W'(s2_vld_q);
    rd_ptr_d = rd_ptr_q + CRED_W'(pop);
    cred_d   = cred_q + CRED_W'(accept) - CRED_W'(pop);
    if (s2_vld_q) begin
      fifo_d[wr_ptr_q[PTR_W-1:0]] = {(s2_oob_q ? {DATA_WIDTH{1'b0}} : bram_douta), s2_tag_q, s2_oob_q};
    end
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      s1_vld_q  <= 1'b0;
      s1_addr_q <= '0;
      s1_tag_q  <= '0;
      s1_oob_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_tag_q  <= '0;
      s2_oob_q  <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cred_q    <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_addr_q <= s1_addr_d;
      s1_tag_q  <= s1_tag_d;
      s1_oob_q  <= s1_oob_d;
      s2_vld_q  <= s2_vld_d;
      s2_tag_q  <= s2_tag_d;
      s2_oob_q  <= s2_oob_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cred_q    <= cred_d;
    end
  end

  // Entry storage needs no reset: outputs are masked until an entry is written.
  always_ff @(posedge clka) begin
    fifo_q <= fifo_d;
  end

  assign bram_ena   = s1_vld_q;
  assign bram_addra = s1_addr_q;
  assign head       = m_valid ? fifo_q[rd_ptr_q[PTR_W-1:0]] : '0;
  assign m_eqid     = head[ENT_W-1 -: DATA_WIDTH];
  assign m_tag      = head[TAG_WIDTH:1];
  assign m_oob      = head[0];

endmodule

// File: tb/tb_phase1_addr_gen.sv
// Scoreboarded bench for phase1_addr_gen with a behavioural BRAM and index model.
module tb_phase1_addr_gen;

`ifdef PHASE1_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic        clka = 1'b0;
  logic        rsta = 1'b1;
  logic [15:0] cfg_num_b = 16'd10;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_id_a = '0;
  logic [15:0] s_id_b = '0;
  logic [7:0]  s_tag = '0;
  logic        bram_ena;
  logic [31:0] bram_addra;
  logic [31:0] bram_douta = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_eqid;
  logic [7:0]  m_tag;
  logic        m_oob;

  typedef struct packed {
    logic [31:0] eqid;
    logic [7:0]  tag;
    logic        oob;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  int          checks = 0;
  int          failures = 0;
  bit          hold_v = 1'b0;
  exp_t        hold_e;

  phase1_addr_gen dut (
    .clka(clka), .rsta(rsta), .cfg_num_b(cfg_num_b),
    .s_valid(s_valid), .s_ready(s_ready), .s_id_a(s_id_a), .s_id_b(s_id_b), .s_tag(s_tag),
    .bram_ena(bram_ena), .bram_addra(bram_addra), .bram_douta(bram_douta),
    .m_valid(m_valid), .m_ready(m_ready), .m_eqid(m_eqid), .m_tag(m_tag), .m_oob(m_oob)
  );

  always #5 clka = ~clka;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hA5A5_0000 ^ {a[15:0], a[31:16]};
  endfunction

  // Synchronous-read BRAM model: one-cycle read latency.
  always @(posedge clka) if (bram_ena) bram_douta <= memf(bram_addra);

  function automatic void ref_model(input int unsigned a, input int unsigned b, input int unsigned nb,
                                    output logic [31:0] addr, output logic [31:0] eqid, output logic oob);
    longint unsigned ix;
    ix   = longint'(a) * longint'(nb) + longint'(b);
    oob  = BC && ((b >= nb) || (ix >= 64'd32768));
    addr = oob ? 32'd0 : ix[31:0];
    eqid = oob ? 32'd0 : memf(addr);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clka) begin : input_mon
    exp_t        e;
    logic [31:0] a;
    logic        o;
    if (s_valid && s_ready) begin
      ref_model(s_id_a, s_id_b, cfg_num_b, a, e.eqid, o);
      e.tag = s_tag;
      e.oob = o;
      exp_q.push_back(e);
      addr_q.push_back(a);
    end
  end

  always @(negedge clka) begin : result_mon
    exp_t e;
    if (hold_v) begin
      chk("hold_vld", m_valid, 1);
      chk("hold_eqid", m_eqid, hold_e.eqid);
      chk("hold_tag", m_tag, hold_e.tag);
      chk("hold_oob", m_oob, hold_e.oob);
    end
    if (bram_ena) begin
      chk("addr_expected", addr_q.size() != 0, 1);
      if (addr_q.size() != 0) chk("bram_addra", bram_addra, addr_q.pop_front());
    end
    if (m_valid && m_ready) begin
      chk("result_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("m_eqid", m_eqid, e.eqid);
        chk("m_tag", m_tag, e.tag);
        chk("m_oob", m_oob, e.oob);
      end
    end
    hold_v = m_valid && !m_ready;
    hold_e = '{eqid: m_eqid, tag: m_tag, oob: m_oob};
    if (rsta) begin
      exp_q.delete();
      addr_q.delete();
      hold_v = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic rnd_req(input bit wild);
    s_id_a = wild ? 16'($urandom) : 16'($urandom_range(0, 120));
    s_id_b = wild ? 16'($urandom_range(0, int'(cfg_num_b) + 3)) : 16'($urandom_range(0, int'(cfg_num_b) - 1));
    s_tag  = 8'($urandom);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    chk(nm, exp_q.size(), 0);
    tick();
    tick();
  endtask

  initial begin
    int n;
    tick();
    tick();
    @(negedge clka);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_bram_ena", bram_ena, 0);
    chk("rst_bram_addra", bram_addra, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_eqid", m_eqid, 0);
    chk("rst_m_tag", m_tag, 0);
    chk("rst_m_oob", m_oob, 0);
    tick();
    rsta = 1'b0;
    @(negedge clka);
    chk("post_rst_s_ready", s_ready, 1);

    // Single lookup: 3*10+7 = 37
    tick();
    m_ready = 1'b1;
    s_valid = 1'b1; s_id_a = 16'd3; s_id_b = 16'd7; s_tag = 8'h5A;
    @(negedge clka);
    chk("single_s_ready", s_ready, 1);
    tick();
    s_valid = 1'b0;
    @(negedge clka);
    chk("single_ena", bram_ena, 1);
    chk("single_addr", bram_addra, 37);
    tick();
    @(negedge clka);
    chk("single_early_vld", m_valid, 0);
    tick();
    @(negedge clka);
    chk("single_vld", m_valid, 1);
    chk("single_eqid", m_eqid, memf(32'd37));
    chk("single_tag", m_tag, 8'h5A);
    drain("single_drain");

    // Boundary indices: id_b == cfg_num_b, and index exactly 32768
    tick();
    s_valid = 1'b1; s_id_a = 16'd0; s_id_b = 16'd10; s_tag = 8'h11;
    tick();
    s_id_a = 16'd3276; s_id_b = 16'd8; s_tag = 8'h22;
    @(negedge clka);
    chk("oob1_addr", bram_addra, BC ? 32'd0 : 32'd10);
    tick();
    s_valid = 1'b0;
    @(negedge clka);
    chk("oob2_addr", bram_addra, BC ? 32'd0 : 32'd32768);
    tick();
    @(negedge clka);
    chk("oob1_vld", m_valid, 1);
    chk("oob1_flag", m_oob, BC);
    chk("oob1_eqid", m_eqid, BC ? 32'd0 : memf(32'd10));
    tick();
    @(negedge clka);
    chk("oob2_flag", m_oob, BC);
    drain("oob_drain");

    // Streaming: 16 back-to-back with m_ready held high
    tick();
    cfg_num_b = 16'($urandom_range(1, 300));
    for (int i = 0; i < 16; i++) begin
      tick();
      s_valid = 1'b1;
      rnd_req(1'b0);
      @(negedge clka);
      chk("stream_s_ready", s_ready, 1);
      chk("stream_m_valid", m_valid, i >= 3);
    end
    tick();
    s_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clka);
      chk("stream_tail_vld", m_valid, 1);
      tick();
    end
    @(negedge clka);
    chk("stream_end_vld", m_valid, 0);
    drain("stream_drain");

    // Backpressure, then simultaneous accept+pop near full credit
    m_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      s_valid = 1'b1;
      rnd_req(1'b0);
      @(negedge clka);
      if (s_valid && s_ready) n++;
    end
    chk("bp_accepts", n, 4);
    chk("bp_s_ready", s_ready, 0);
    tick();
    m_ready = 1'b1;
    rnd_req(1'b0);
    @(negedge clka);
    chk("simul_first_rdy", s_ready, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      rnd_req(1'b0);
      @(negedge clka);
      chk("simul_s_ready", s_ready, 1);
      chk("simul_m_valid", m_valid, 1);
    end
    tick();
    drain("simul_drain");

    // Reset with two reads in flight and one entry in the FIFO
    m_ready = 1'b0;
    tick(); s_valid = 1'b1; rnd_req(1'b0);
    tick(); rnd_req(1'b0);
    tick(); rnd_req(1'b0);
    tick(); s_valid = 1'b0; rsta = 1'b1;
    @(negedge clka);
    chk("rst_mid_pre_vld", m_valid, 1);
    tick();
    rsta = 1'b0;
    @(negedge clka);
    chk("rst_mid_m_valid", m_valid, 0);
    chk("rst_mid_s_ready", s_ready, 1);
    chk("rst_mid_ena", bram_ena, 0);
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge clka);
      chk("rst_no_stale", m_valid, 0);
    end
    m_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      s_valid = 1'b1;
      rnd_req(1'b0);
      @(negedge clka);
      if (s_valid && s_ready) n++;
    end
    chk("rst_credits_clear", n, 4);
    drain("rst_drain");

    // Random traffic, occasional out-of-range and wide ids
    for (int b = 0; b < 3; b++) begin
      cfg_num_b = 16'($urandom_range(1, 300));
      for (int c = 0; c < 150; c++) begin
        tick();
        s_valid = ($urandom_range(0, 3) != 0);
        m_ready = ($urandom_range(0, 3) != 0);
        rnd_req($urandom_range(0, 7) == 0);
      end
      tick();
      drain("rand_drain");
    end

    chk("final_addr_q_empty", addr_q.size(), 0);
    chk("final_m_valid", m_valid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
